// File: rtl/baud_pkg.sv
// Shared definitions for the runtime-configurable baud tick controller.
package baud_pkg;

   localparam int DEFAULT_MOD = 163;
   localparam int OVERSAMPLE  = 16;
   localparam int MIN_MOD     = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      APPLY = 2'd2
   } state_e;

endpackage

// File: rtl/baud_divider.sv
// Free-running divide-by-i_mod counter producing a one-cycle tick on its last count.
module baud_divider #(
   parameter int NB_COUNTER = 9
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NB_COUNTER-1:0] i_mod,
   input  logic                  i_en,
   input  logic                  i_clear,
   output logic                  o_tick
);

   localparam logic [NB_COUNTER-1:0] ONE = NB_COUNTER'(1);

   logic [NB_COUNTER-1:0] cnt_q;
   logic [NB_COUNTER-1:0] cnt_d;
   logic                  last_count;

   assign last_count = (cnt_q == (i_mod - ONE));
   assign o_tick     = i_en && last_count;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = last_count ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/baud_ctrl.sv
// Baud tick controller: owns the divisor, emits 16x/1x ticks and swaps the
// divisor only between frames via a valid/ready configuration handshake.
module baud_ctrl #(
   parameter int NB_COUNTER  = 9,
   parameter int DEFAULT_MOD = baud_pkg::DEFAULT_MOD,
   parameter int OVERSAMPLE  = baud_pkg::OVERSAMPLE
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_cfg_valid,
   input  logic [NB_COUNTER-1:0] i_cfg_mod,
   output logic                  o_cfg_ready,
   output logic                  o_cfg_done,
   output logic                  o_cfg_err,
   input  logic                  i_tx_busy,
   input  logic                  i_rx_busy,
   output logic                  o_tick,
   output logic                  o_tx_tick,
   output logic [NB_COUNTER-1:0] o_mod
);

   import baud_pkg::*;

   localparam int                    NB_SUB  = $clog2(OVERSAMPLE);
   localparam logic [NB_SUB-1:0]     SUB_MAX = NB_SUB'(OVERSAMPLE - 1);
   localparam logic [NB_SUB-1:0]     SUB_ONE = NB_SUB'(1);
   localparam logic [NB_COUNTER-1:0] RST_MOD = NB_COUNTER'(DEFAULT_MOD);
   localparam logic [NB_COUNTER-1:0] LOW_MOD = NB_COUNTER'(MIN_MOD);

   state_e                state_q, state_d;
   logic [NB_COUNTER-1:0] mod_q, mod_d;
   logic [NB_COUNTER-1:0] pend_q, pend_d;
   logic [NB_SUB-1:0]     sub_q, sub_d;
   logic                  err_q, err_d;

   logic div_en;
   logic div_clear;
   logic tick;

   // The APPLY cycle restarts the divider from zero at the new rate.
   assign div_clear = (state_q == APPLY);
   assign div_en    = i_enable && !div_clear;

   baud_divider #(
      .NB_COUNTER (NB_COUNTER)
   ) u_divider (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_mod   (mod_q),
      .i_en    (div_en),
      .i_clear (div_clear),
      .o_tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      mod_d   = mod_q;
      pend_d  = pend_q;
      sub_d   = sub_q;
      err_d   = 1'b0;

      unique case (state_q)
         RUN: begin
            if (i_cfg_valid) begin
               if (i_cfg_mod >= LOW_MOD) begin
                  pend_d  = i_cfg_mod;
                  state_d = PEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // Hold the old rate until neither side is mid-frame.
         PEND: begin
            if (!i_tx_busy && !i_rx_busy) begin
               state_d = APPLY;
            end
         end
         APPLY: begin
            mod_d   = pend_q;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      if (div_clear) begin
         sub_d = '0;
      end else if (tick) begin
         sub_d = sub_q + SUB_ONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= RUN;
         mod_q   <= RST_MOD;
         pend_q  <= RST_MOD;
         sub_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mod_q   <= mod_d;
         pend_q  <= pend_d;
         sub_q   <= sub_d;
         err_q   <= err_d;
      end
   end

   assign o_tick      = tick;
   assign o_tx_tick   = tick && (sub_q == SUB_MAX);
   assign o_cfg_ready = (state_q == RUN);
   assign o_cfg_done  = (state_q == APPLY);
   assign o_cfg_err   = err_q;
   assign o_mod       = mod_q;

endmodule
